reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 35 +++
 rtl/reset_sequencer_seq_timer.sv | 27 ++
 rtl/reset_sequencer.sv | 132 +++++++++++++
 tb/tb_reset_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encoding, default timing parameters and helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelSram,
    StRelUsb,
    StRelEth,
    StRun,
    StFault
  } seq_state_e;

  localparam int unsigned DefPllRstCyc  = 8;
  localparam int unsigned DefLockTimeout = 65535;
  localparam int unsigned DefStableCyc  = 1024;
  localparam int unsigned DefGapCyc     = 16;
  localparam int unsigned DefMaxRetry   = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Next state of the release chain once a gap expires.
  function automatic seq_state_e next_rel(input seq_state_e s);
    case (s)
      StRelSram: return StRelUsb;
      StRelUsb:  return StRelEth;
      StRelEth:  return StRun;
      default:   return s;
    endcase
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Loadable saturating down-counter with a zero flag, shared by every wait phase.
module seq_timer #(
  parameter int unsigned Width  = 8,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= RstVal;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: PLL reset, lock qualification, then staged sram/usb/eth release.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC  = DefPllRstCyc,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned STABLE_CYC   = DefStableCyc,
  parameter int unsigned GAP_CYC      = DefGapCyc,
  parameter int unsigned MAX_RETRY    = DefMaxRetry
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  input  logic       fault_clr,
  output logic       pll_areset,
  output logic       sram_rst_n,
  output logic       usb_rst_n,
  output logic       eth_rst_n,
  output logic       seq_done,
  output logic       seq_fault,
  output logic [1:0] retry_cnt
);

  localparam int unsigned MaxCyc =
    max_u(max_u(PLL_RST_CYC, LOCK_TIMEOUT), max_u(STABLE_CYC, GAP_CYC));
  localparam int unsigned CntW = $clog2(MaxCyc + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Timer holds "cycles remaining after this one", so each phase loads its length minus one.
  localparam cnt_t LdPllRst = cnt_t'(PLL_RST_CYC - 1);
  localparam cnt_t LdLock   = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t LdStable = cnt_t'(STABLE_CYC - 1);
  localparam cnt_t LdGap    = cnt_t'(GAP_CYC - 1);

  seq_state_e r_state, w_state_d;
  logic [1:0] r_retry;
  logic       r_pll_areset, r_sram, r_usb, r_eth, r_done, r_fault;
  logic       w_tmr_zero, w_tmr_load, w_retry_last;
  cnt_t       w_tmr_val;

  assign w_retry_last = ((32'(r_retry) + 32'd1) == MAX_RETRY);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StPllRst: begin
        if (w_tmr_zero) w_state_d = StWaitLock;
      end
      StWaitLock: begin
        if (pll_locked)      w_state_d = StStable;
        else if (w_tmr_zero) w_state_d = w_retry_last ? StFault : StPllRst;
      end
      StStable: begin
        if (!pll_locked)     w_state_d = StWaitLock;
        else if (w_tmr_zero) w_state_d = StRelSram;
      end
      StRelSram, StRelUsb, StRelEth, StRun: begin
        // Lock loss outranks a soft request.
        if (!pll_locked)                         w_state_d = StPllRst;
        else if (soft_rst_req)                   w_state_d = StStable;
        else if (w_tmr_zero && r_state != StRun) w_state_d = next_rel(r_state);
      end
      StFault: begin
        if (fault_clr) w_state_d = StPllRst;
      end
      default: w_state_d = StPllRst;
    endcase
  end

  // Every state change reloads the timer with the length of the state being entered.
  always_comb begin
    w_tmr_load = (w_state_d != r_state);
    case (w_state_d)
      StPllRst:                      w_tmr_val = LdPllRst;
      StWaitLock:                    w_tmr_val = LdLock;
      StStable:                      w_tmr_val = LdStable;
      StRelSram, StRelUsb, StRelEth: w_tmr_val = LdGap;
      default:                       w_tmr_val = '0;
    endcase
  end

  seq_timer #(
    .Width  (CntW),
    .RstVal (LdPllRst)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= StPllRst;
      r_retry      <= '0;
      r_pll_areset <= 1'b1;
      r_sram       <= 1'b0;
      r_usb        <= 1'b0;
      r_eth        <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StWaitLock && w_state_d == StPllRst) begin
        if (r_retry != 2'b11) r_retry <= r_retry + 2'd1;
      end else if ((w_state_d == StRun && r_state != StRun) ||
                   (r_state == StFault && w_state_d == StPllRst)) begin
        r_retry <= '0;
      end
      r_pll_areset <= (w_state_d == StPllRst) || (w_state_d == StFault);
      r_sram       <= (w_state_d == StRelSram) || (w_state_d == StRelUsb) ||
                      (w_state_d == StRelEth)  || (w_state_d == StRun);
      r_usb        <= (w_state_d == StRelUsb) || (w_state_d == StRelEth) ||
                      (w_state_d == StRun);
      r_eth        <= (w_state_d == StRelEth) || (w_state_d == StRun);
      r_done       <= (w_state_d == StRun);
      r_fault      <= (w_state_d == StFault);
    end
  end

  assign pll_areset = r_pll_areset;
  assign sram_rst_n = r_sram;
  assign usb_rst_n  = r_usb;
  assign eth_rst_n  = r_eth;
  assign seq_done   = r_done;
  assign seq_fault  = r_fault;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer using short verification timing parameters.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic       pll_areset, sram_rst_n, usb_rst_n, eth_rst_n, seq_done, seq_fault;
  logic [1:0] retry_cnt;
  logic [7:0] w_obs;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  reset_sequencer #(
    .PLL_RST_CYC  (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYC   (8),
    .GAP_CYC      (2),
    .MAX_RETRY    (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .fault_clr    (fault_clr),
    .pll_areset   (pll_areset),
    .sram_rst_n   (sram_rst_n),
    .usb_rst_n    (usb_rst_n),
    .eth_rst_n    (eth_rst_n),
    .seq_done     (seq_done),
    .seq_fault    (seq_fault),
    .retry_cnt    (retry_cnt)
  );

  // {areset, sram, usb, eth, done, fault, retry[1:0]}
  assign w_obs = {pll_areset, sram_rst_n, usb_rst_n, eth_rst_n, seq_done, seq_fault, retry_cnt};

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Each cycle: push the expected output vector, clock once, then pop and compare.
  task automatic run(input int n, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, i), w_obs, e);
    end
  endtask

  // From PLL_RST entry with lock held high: 4 areset cycles, 8 stable, 2-cycle gaps, RUN.
  task automatic full_seq(input string tag);
    pll_locked = 1'b1;
    run(3, 8'h80, {tag, "_pllrst"});
    run(9, 8'h00, {tag, "_lockwait"});
    run(2, 8'h40, {tag, "_sram"});
    run(2, 8'h60, {tag, "_usb"});
    run(2, 8'h70, {tag, "_eth"});
    run(3, 8'h78, {tag, "_run"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    reset_n = 1'b0;
    run(2, 8'h80, "reset");
    reset_n = 1'b1;
    full_seq("boot");

    // Lock loss in RUN, then two lock timeouts into FAULT; soft requests ignored meanwhile.
    pll_locked = 1'b0;
    run(4, 8'h80, "lockloss_pllrst");
    run(32, 8'h00, "waitlock1");
    run(4, 8'h81, "retry1_pllrst");
    soft_rst_req = 1'b1;
    run(32, 8'h01, "waitlock2_soft_ignored");
    soft_rst_req = 1'b0;
    run(3, 8'h85, "fault_hold");

    // fault_clr, then lock drops on the 5th STABLE cycle.
    fault_clr = 1'b1;
    run(1, 8'h80, "fault_clr");
    fault_clr = 1'b0;
    pll_locked = 1'b1;
    run(3, 8'h80, "clr_pllrst");
    run(1, 8'h00, "clr_waitlock");
    run(5, 8'h00, "stable_pre_drop");
    pll_locked = 1'b0;
    run(1, 8'h00, "stable_drop");
    pll_locked = 1'b1;
    run(8, 8'h00, "restable");
    run(2, 8'h40, "restable_sram");
    run(1, 8'h60, "usb_entry");

    // One-cycle reset during REL_USB.
    reset_n = 1'b0;
    run(1, 8'h80, "midseq_reset");
    reset_n = 1'b1;
    full_seq("reboot");

    // Soft reset in RUN keeps the PLL running.
    soft_rst_req = 1'b1;
    run(1, 8'h00, "soft_entry");
    soft_rst_req = 1'b0;
    run(7, 8'h00, "soft_stable");
    run(2, 8'h40, "soft_sram");
    run(2, 8'h60, "soft_usb");
    run(2, 8'h70, "soft_eth");
    run(1, 8'h78, "soft_run");

    // Soft request together with lock loss goes to PLL_RST.
    soft_rst_req = 1'b1;
    pll_locked = 1'b0;
    run(1, 8'h80, "soft_and_lockloss");
    soft_rst_req = 1'b0;
    full_seq("after_both");

    // One timeout then success: RUN entry clears retry_cnt.
    pll_locked = 1'b0;
    run(4, 8'h80, "rc_pllrst");
    run(32, 8'h00, "rc_waitlock");
    run(4, 8'h81, "rc_retry_pllrst");
    pll_locked = 1'b1;
    run(9, 8'h01, "rc_lockwait");
    run(2, 8'h41, "rc_sram");
    run(2, 8'h61, "rc_usb");
    run(2, 8'h71, "rc_eth");
    run(2, 8'h78, "rc_run_cleared");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
